sfetch: RTL and testbench
=========================

Name: sfetch

Overview:
- Instruction fetch stage sitting directly upstream of sdecode.
- Issues sequential word fetches to instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers fetched words in a small FIFO and presents them to decode with valid/ready.
- On a redirect (taken branch/jump) it flushes the FIFO, discards in-flight responses and restarts at the redirect target.

Parameters:
- DATA_WIDTH, 32, width of instruction word and PC.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries and maximum outstanding requests; power of two, ≥2.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  reset; asynchronous, active-low.
- imem_req_valid_o  output  1  fetch request valid.
- imem_req_ready_i  input  1  memory accepts request.
- imem_req_addr_o  output  DATA_WIDTH  word-aligned fetch address.
- imem_rsp_valid_i  input  1  response valid; responses return in request order, one per cycle max.
- imem_rsp_data_i  input  DATA_WIDTH  fetched instruction.
- redirect_i  input  1  flush and restart fetch.
- redirect_pc_i  input  DATA_WIDTH  new fetch PC; bits [1:0] ignored (treated as 0).
- instr_o  output  DATA_WIDTH  instruction at FIFO head; 32'h0000_0013 (NOP) when FIFO empty.
- instr_pc_o  output  DATA_WIDTH  PC of instr_o; 0 when empty.
- instr_valid_o  output  1  head valid to decode.
- instr_ready_i  input  1  decode consumes head.

Behaviour:
- Reset (async assert): fetch_pc=RESET_PC, state=BOOT, FIFO empty, outstanding_cnt=0, drop_cnt=0. imem_req_valid_o=0, instr_valid_o=0, instr_o=NOP, instr_pc_o=0.
- FSM:
  - BOOT: no requests; always → RUN on the next clk.
  - RUN: normal fetch. On redirect_i: if (outstanding_cnt − rsp this cycle) > 0 → DRAIN, else stay in RUN.
  - DRAIN: no requests issued; each response is discarded and decrements drop_cnt; → RUN when drop_cnt reaches 0, including the cycle of the last discard.
- Request: imem_req_valid_o = (state==RUN) && !redirect_i && (fifo_count + outstanding_cnt < FIFO_DEPTH).
  - imem_req_addr_o = fetch_pc, a register.
  - On valid&&ready: fetch_pc += 4 (modulo 2^DATA_WIDTH; wraps 0xFFFF_FFFC→0) and outstanding_cnt += 1.
  - An unaccepted request may be withdrawn only by redirect; otherwise valid and addr are held stable until ready.
- Response:
  - If drop_cnt > 0: discard the response, drop_cnt −= 1.
  - Otherwise push {data, pc} into the FIFO. The response PC comes from a parallel in-order PC queue or equivalent tracking.
  - outstanding_cnt −= 1 for every response, kept or dropped.
  - Simultaneous request-accept and response in one cycle: net outstanding_cnt change is 0.
- Credit rule guarantees no FIFO overflow. A response arriving while outstanding_cnt==0 is a protocol error: ignored, with an assertion.
- Output: instr_valid_o = fifo non-empty && !redirect_i. Pop on instr_valid_o && instr_ready_i. Simultaneous push and pop when full is legal.
- Redirect (highest priority, takes effect at the clock edge):
  - FIFO cleared.
  - fetch_pc = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00}.
  - drop_cnt = outstanding_cnt − (imem_rsp_valid_i ? 1:0); any response arriving in the redirect cycle is discarded.
  - Redirect during DRAIN: the target is updated and draining continues with the same rule.
- First request is issued in the cycle after BOOT, i.e. the second clk edge after reset release. Fetch-to-decode latency is memory latency + 1 cycle (FIFO write then head visible).
- Counter widths: $clog2(FIFO_DEPTH+1) bits.

Optional Feature:
- Macro SFETCH_PERF_EN.
- Defined: adds outputs perf_fetched_o [31:0] and perf_bubble_o [31:0].
  - perf_fetched_o counts responses pushed into the FIFO.
  - perf_bubble_o counts cycles with instr_valid_o==0 && instr_ready_i==1.
  - Both are reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory always ready, 1-cycle latency, decode always ready → requests at 0x0,0x4,0x8,… on consecutive cycles; instr_o/instr_pc_o stream back in order; no bubbles after fill.
- Decode ready held low → exactly FIFO_DEPTH(4) requests issued, then imem_req_valid_o=0; after releasing ready, 4 instructions popped in order and fetch resumes at 0x10.
- Memory ready low for 3 cycles → imem_req_addr_o held at the same value and valid held high; single accept once ready rises.
- Two requests outstanding (0x20, 0x24), redirect to 0x103 → FIFO flushed, both responses discarded in DRAIN, next request addr 0x100, first delivered instr_pc_o=0x100.
- Redirect in the same cycle a response arrives, with 1 outstanding → response dropped, no DRAIN entry, next request issued the following cycle at the target.
- fetch_pc at 0xFFFF_FFFC → next request addr 0x0000_0000; async reset asserted mid-stream → all outputs return to reset values immediately, with no request pending.

Source files
------------

// File: rtl/sfetch.sv
// rtl/sfetch.sv - instruction fetch stage: sequential imem requests, response FIFO, redirect flush/drain (optional SFETCH_PERF_EN counters)
module sfetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid_o,
    input  logic                  imem_req_ready_i,
    output logic [DATA_WIDTH-1:0] imem_req_addr_o,
    input  logic                  imem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o,
    output logic                  instr_valid_o,
`ifdef SFETCH_PERF_EN
    output logic [31:0]           perf_fetched_o,
    output logic [31:0]           perf_bubble_o,
`endif
    input  logic                  instr_ready_i
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]         out_cnt_q, out_cnt_d;
    logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];

    logic rsp_fire, rsp_keep, req_valid, req_fire, fifo_empty, head_valid, pop;

    always_comb begin
        fifo_empty = (fifo_cnt_q == '0);
        head_valid = !fifo_empty && !redirect_i;
        pop        = head_valid && instr_ready_i;
        rsp_fire   = imem_rsp_valid_i && (out_cnt_q != '0);
        rsp_keep   = rsp_fire && !redirect_i && (drop_cnt_q == '0);
        // Credits cover both buffered words and words still in flight
        req_valid  = (state_q == ST_RUN) && !redirect_i &&
                     (({1'b0, fifo_cnt_q} + {1'b0, out_cnt_q}) < (CW+1)'(FIFO_DEPTH));
        req_fire   = req_valid && imem_req_ready_i;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(rsp_fire);
        drop_cnt_d = drop_cnt_q;
        fifo_cnt_d = fifo_cnt_q + CW'(rsp_keep) - CW'(pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (req_fire) fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
        if (rsp_keep) begin
            rsp_pc_d = rsp_pc_q + DATA_WIDTH'(4);
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        if (rsp_fire && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);

        // Redirect wins: everything older than this edge is stale
        if (redirect_i) begin
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
            rsp_pc_d   = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
            drop_cnt_d = out_cnt_q - CW'(rsp_fire);
        end

        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN,
            ST_DRAIN: state_d = (drop_cnt_d != '0) ? ST_DRAIN : ST_RUN;
            default:  state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= {RESET_PC[DATA_WIDTH-1:2], 2'b00};
            rsp_pc_q   <= {RESET_PC[DATA_WIDTH-1:2], 2'b00};
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage is qualified by fifo_cnt_q, so it needs no reset
    always_ff @(posedge clk) begin
        if (rsp_keep) begin
            fifo_data_q[wr_ptr_q] <= imem_rsp_data_i;
            fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = fetch_pc_q;
    assign instr_valid_o    = head_valid;
    assign instr_o          = fifo_empty ? NOP : fifo_data_q[rd_ptr_q];
    assign instr_pc_o       = fifo_empty ? '0  : fifo_pc_q[rd_ptr_q];

    rsp_while_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid_i && out_cnt_q == '0));

`ifdef SFETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_bubble_d  = perf_bubble_q;
        if (rsp_keep && perf_fetched_q != 32'hFFFF_FFFF)
            perf_fetched_d = perf_fetched_q + 32'd1;
        if (!head_valid && instr_ready_i && perf_bubble_q != 32'hFFFF_FFFF)
            perf_bubble_d = perf_bubble_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_bubble_q  <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_bubble_q  <= perf_bubble_d;
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_bubble_o  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_sfetch.sv
// tb/tb_sfetch.sv - randomized self-checking bench for sfetch against a queue-based fetch model
module tb_sfetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid_o, imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o, instr_pc_o;
    logic        instr_valid_o, instr_ready_i;

    always #5 clk = ~clk;

    sfetch #(.DATA_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o(imem_req_addr_o),
        .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i)
    );

    typedef struct {
        logic [31:0] maddr;
        logic [31:0] epc;
        int          gen;
        int          rdy;
    } req_t;

    req_t        pend[$];
    logic [31:0] fifo_m[$];
    int          gen, cyc;
    logic [31:0] fpc;
    bit          booted;
    int          n_vec, n_err;
    int          p_mem, p_dec, p_rsp, p_redir, lat_max;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        fifo_m.delete();
        gen    = 0;
        fpc    = 32'h0;
        booted = 0;
    endtask

    task automatic idle_inputs();
        imem_req_ready_i = 0;
        imem_rsp_valid_i = 0;
        imem_rsp_data_i  = 0;
        redirect_i       = 0;
        redirect_pc_i    = 0;
        instr_ready_i    = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, imem_req_valid_o, 32'd0);
        check({tag, "_req_addr"}, imem_req_addr_o, 32'h0);
        check({tag, "_instr_valid"}, instr_valid_o, 32'd0);
        check({tag, "_instr"}, instr_o, 32'h0000_0013);
        check({tag, "_instr_pc"}, instr_pc_o, 32'h0);
    endtask

    // One cycle: drive at negedge, check combinational outputs, advance model, cross posedge
    task automatic step(input bit force_redir, input logic [31:0] force_tgt);
        bit          exp_rv, stale;
        logic [31:0] tgt;
        req_t        r;
        @(negedge clk);
        imem_req_ready_i = ($urandom_range(99) < p_mem);
        instr_ready_i    = ($urandom_range(99) < p_dec);
        redirect_i       = force_redir || ($urandom_range(999) < p_redir);
        tgt              = force_redir ? force_tgt : $urandom;
        redirect_pc_i    = tgt;
        imem_rsp_valid_i = 0;
        imem_rsp_data_i  = $urandom;
        if (pend.size() > 0 && pend[0].rdy <= cyc && $urandom_range(99) < p_rsp) begin
            imem_rsp_valid_i = 1;
            imem_rsp_data_i  = mem_word(pend[0].maddr);
        end
        #1;
        stale  = pend.size() > 0 && pend[0].gen != gen;
        exp_rv = booted && !redirect_i && !stale && (fifo_m.size() + pend.size() < 4);
        check("req_valid", imem_req_valid_o, exp_rv);
        if (exp_rv) check("req_addr", imem_req_addr_o, fpc);
        check("instr_valid", instr_valid_o, fifo_m.size() > 0 && !redirect_i);
        if (fifo_m.size() > 0) begin
            check("instr_pc", instr_pc_o, fifo_m[0]);
            check("instr", instr_o, mem_word(fifo_m[0]));
        end else begin
            check("instr_empty", instr_o, 32'h0000_0013);
            check("instr_pc_empty", instr_pc_o, 32'h0);
        end

        if (instr_valid_o && instr_ready_i && fifo_m.size() > 0) void'(fifo_m.pop_front());
        if (imem_rsp_valid_i) begin
            r = pend.pop_front();
            if (r.gen == gen && !redirect_i) fifo_m.push_back(r.epc);
        end
        if (imem_req_valid_o && imem_req_ready_i) begin
            pend.push_back('{maddr: imem_req_addr_o, epc: fpc, gen: gen,
                             rdy: cyc + 1 + int'($urandom_range(lat_max))});
            fpc = fpc + 32'd4;
        end
        if (redirect_i) begin
            fifo_m.delete();
            gen++;
            fpc = {tgt[31:2], 2'b00};
        end
        booted = 1;
        @(posedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1;
        #1;
        check_reset_outputs("boot");
        @(posedge clk);
        cyc++;
        booted = 1;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        idle_inputs();
        model_reset();
        rst_n = 0;
        #12;
        check_reset_outputs("reset");
        release_reset();

        p_mem = 100; p_dec = 100; p_rsp = 100; p_redir = 0; lat_max = 0;
        run(40);

        p_dec = 0;
        run(20);
        p_dec = 100;
        run(20);

        p_mem = 30;
        run(30);
        p_mem = 100;

        // Directed redirect to an unaligned target, then a redirect on a response cycle
        step(1'b1, 32'h0000_0103);
        run(15);
        step(1'b1, 32'h0000_0200);
        run(10);

        p_mem = 70; p_dec = 70; p_rsp = 70; p_redir = 60; lat_max = 3;
        run(400);

        p_mem = 100; p_dec = 100; p_rsp = 100; p_redir = 0; lat_max = 1;
        step(1'b1, 32'hFFFF_FFF9);
        run(20);

        // Asynchronous reset between clock edges
        p_mem = 80; p_dec = 60; p_rsp = 80;
        run(7);
        @(negedge clk);
        idle_inputs();
        #2;
        rst_n = 0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge clk);
        cyc++;
        release_reset();

        p_mem = 75; p_dec = 75; p_rsp = 75; p_redir = 40; lat_max = 2;
        run(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
